// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request to instruction memory and
// buffers one instruction for IF/ID. Define IF_MISALIGN_CHECK_EN to trap misaligned redirects.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFIDWrite,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] A
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
`ifdef IF_MISALIGN_CHECK_EN
        ,
        S_FAULT = 2'd3
`endif
    } state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic [63:0] inflight_pc, inflight_next;
    logic        buf_valid, buf_valid_next;
    logic [31:0] buf_inst;
    logic [63:0] buf_pc;
    logic        buf_load;
    logic        accept;

    // Requests are issued only when the buffer is empty or being consumed, so WAIT always
    // finds an empty buffer.
    always_comb begin
        imem_req = 1'b0;
        if (!reset && state == S_REQ)
            imem_req = !buf_valid || !IFIDWrite;
    end

    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned
        // and no latch is inferred.
        state_next     = state;
        pc_next        = pc;
        inflight_next  = inflight_pc;
        buf_valid_next = buf_valid && IFIDWrite;
        buf_load       = 1'b0;

        case (state)
            S_REQ: begin
                if (accept) begin
                    inflight_next = pc;
                    pc_next       = pc + 64'd4;
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    buf_load       = 1'b1;
                    buf_valid_next = 1'b1;
                    state_next     = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid)
                    state_next = S_REQ;
            end
            default: ;
        endcase

        // A redirect overrides everything; an accepted old-PC request must still be drained.
        if (branch_taken) begin
            pc_next        = branch_target;
            buf_valid_next = 1'b0;
            buf_load       = 1'b0;
            case (state)
                S_REQ:           state_next = accept ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_next = imem_rvalid ? S_REQ : S_DRAIN;
                default:         state_next = S_REQ;
            endcase
`ifdef IF_MISALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00)
                state_next = S_FAULT;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            buf_valid   <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            inflight_pc <= inflight_next;
            buf_valid   <= buf_valid_next;
        end
    end

    // NOTE: buffer payload is left unreset; it is never observed while buf_valid is low.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_inst <= imem_rdata;
            buf_pc   <= inflight_pc;
        end
    end

    assign instruction = buf_valid ? buf_inst : 32'h0;
    assign A           = buf_valid ? buf_pc : 64'h0;

`ifdef IF_MISALIGN_CHECK_EN
    assign fetch_fault = (state == S_FAULT);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a hand-driven instruction memory.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFIDWrite;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] A;
`ifdef IF_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk          (clk),
        .reset        (reset),
        .IFIDWrite    (IFIDWrite),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .A            (A)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .fetch_fault  (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed pattern of the address, so stale data is distinguishable.
    function automatic logic [31:0] inst_of(input logic [63:0] addr);
        return 32'h1300_0013 ^ addr[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; IFIDWrite = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        #3;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, 64'h1000);
        check("rst_A", A, 64'h0);
        check("rst_inst", 64'(instruction), 64'h0);
`ifdef IF_MISALIGN_CHECK_EN
        check("rst_fault", 64'(fetch_fault), 64'd0);
`endif
        tick(); tick();
        reset = 1'b0;
        #1;
        check("z0_req", 64'(imem_req), 64'd1);
        check("z0_addr", imem_addr, 64'h1000);

        // Zero-wait memory, IF/ID always capturing.
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h1000); #1;
        check("z1_req_wait", 64'(imem_req), 64'd0);
        check("z1_A_empty", A, 64'h0);
        tick(); imem_rvalid = 1'b0; #1;
        check("z2_A", A, 64'h1000);
        check("z2_inst", 64'(instruction), 64'(inst_of(64'h1000)));
        check("z2_req", 64'(imem_req), 64'd1);
        check("z2_addr", imem_addr, 64'h1004);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h1004); #1;
        check("z3_A_bubble", A, 64'h0);
        check("z3_inst_bubble", 64'(instruction), 64'h0);
        tick(); imem_rvalid = 1'b0; IFIDWrite = 1'b1; #1;
        check("z4_A", A, 64'h1004);

        // Hold with a full buffer.
        for (int i = 0; i < 5; i++) begin
            check("hold_req", 64'(imem_req), 64'd0);
            check("hold_A", A, 64'h1004);
            check("hold_inst", 64'(instruction), 64'(inst_of(64'h1004)));
            tick();
        end
        IFIDWrite = 1'b0; #1;
        check("rel_req", 64'(imem_req), 64'd1);
        check("rel_addr", imem_addr, 64'h1008);

        // Redirect while waiting: the 0x1008 response must be dropped.
        tick(); branch_taken = 1'b1; branch_target = 64'h2000; #1;
        check("rw_A_consumed", A, 64'h0);
        check("rw_req_wait", 64'(imem_req), 64'd0);
        tick(); branch_taken = 1'b0; #1;
        check("rw_drain_req", 64'(imem_req), 64'd0);
        check("rw_drain_addr", imem_addr, 64'h2000);
        tick();
        check("rw_drain_req2", 64'(imem_req), 64'd0);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h1008); #1;
        tick(); imem_rvalid = 1'b0; #1;
        check("rw_dropped_A", A, 64'h0);
        check("rw_dropped_inst", 64'(instruction), 64'h0);
        check("rw_req", 64'(imem_req), 64'd1);
        check("rw_addr", imem_addr, 64'h2000);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h2000); #1;
        tick(); imem_rvalid = 1'b0; #1;
        check("rw_A", A, 64'h2000);
        check("rw_inst", 64'(instruction), 64'(inst_of(64'h2000)));
        check("ra_req", 64'(imem_req), 64'd1);
        check("ra_addr", imem_addr, 64'h2004);

        // Redirect on the same edge the 0x2004 request is accepted.
        branch_taken = 1'b1; branch_target = 64'h3000;
        tick(); branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = inst_of(64'h2004); #1;
        check("ra_A_cleared", A, 64'h0);
        check("ra_drain_req", 64'(imem_req), 64'd0);
        check("ra_drain_addr", imem_addr, 64'h3000);
        tick(); imem_rvalid = 1'b0; #1;
        check("ra_stale_A", A, 64'h0);
        check("ra_req", 64'(imem_req), 64'd1);
        check("ra_target_addr", imem_addr, 64'h3000);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h3000); #1;
        tick(); imem_rvalid = 1'b0; #1;
        check("ra_A", A, 64'h3000);
        check("ra_next_addr", imem_addr, 64'h3004);

        // Redirect without accept, then PC wrap.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); branch_taken = 1'b0; imem_ready = 1'b1; #1;
        check("wr_A_cleared", A, 64'h0);
        check("wr_req", 64'(imem_req), 64'd1);
        check("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'hFFFF_FFFF_FFFF_FFFC); #1;
        check("wr_wrap_addr", imem_addr, 64'h0);
        check("wr_wait_req", 64'(imem_req), 64'd0);
        tick(); imem_rvalid = 1'b0; #1;
        check("wr_A", A, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_inst", 64'(instruction), 64'(inst_of(64'hFFFF_FFFF_FFFF_FFFC)));
        check("wr_next_req", 64'(imem_req), 64'd1);

        // Misaligned redirect.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h2002;
        tick(); branch_taken = 1'b0; imem_ready = 1'b1; #1;
        check("mis_A_cleared", A, 64'h0);
`ifdef IF_MISALIGN_CHECK_EN
        check("mis_fault", 64'(fetch_fault), 64'd1);
        check("mis_req", 64'(imem_req), 64'd0);
        tick();
        check("mis_fault_hold", 64'(fetch_fault), 64'd1);
        check("mis_req_hold", 64'(imem_req), 64'd0);
        branch_taken = 1'b1; branch_target = 64'h3000;
        tick(); branch_taken = 1'b0; #1;
        check("mis_clear", 64'(fetch_fault), 64'd0);
        check("mis_req_after", 64'(imem_req), 64'd1);
        check("mis_addr_after", imem_addr, 64'h3000);
`else
        check("mis_req", 64'(imem_req), 64'd1);
        check("mis_addr", imem_addr, 64'h2002);
        tick(); imem_rvalid = 1'b1; imem_rdata = inst_of(64'h2002); #1;
        tick(); imem_rvalid = 1'b0; #1;
        check("mis_A", A, 64'h2002);
        check("mis_next_addr", imem_addr, 64'h2006);
`endif

        // Asynchronous reset in the middle of WAIT.
        tick();
        check("mr_wait_req", 64'(imem_req), 64'd0);
        #2; reset = 1'b1; #1;
        check("mr_req", 64'(imem_req), 64'd0);
        check("mr_addr", imem_addr, 64'h1000);
        check("mr_A", A, 64'h0);
        check("mr_inst", 64'(instruction), 64'h0);
        #2; reset = 1'b0; #1;
        check("mr_post_req", 64'(imem_req), 64'd1);
        check("mr_post_addr", imem_addr, 64'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
